// File: rtl/internet_protocol_rx.sv
// internet_protocol_rx: IPv4 header checker/stripper; N-bit MSB-first stream in, IP payload out.
// Defining IP_RX_DST_FILTER_EN restricts accepted destinations to LOCAL_IP or broadcast.
module internet_protocol_rx #(
  parameter int          N        = 4,
  parameter logic [31:0] LOCAL_IP = 32'h12126B0D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         axiiv,
  input  logic [N-1:0] axiid,
  output logic         axiov,
  output logic [N-1:0] axiod,
  output logic         axi_last,
  output logic         hdr_valid,
  output logic [31:0]  src_ip_out,
  output logic [31:0]  dst_ip_out,
  output logic [7:0]   protocol_out,
  output logic [15:0]  data_length_out,
  output logic         err
);

  localparam logic [15:0] HDR_LAST = 16'(160 / N - 1);
  localparam logic [2:0]  SUB_LAST = 3'(8 / N - 1);

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_TRAIL, S_DROP} state_t;
  state_t state, state_next;

  logic [159-N:0] hdr_shift;
  logic [159:0]   hdr_next;
  logic [15:0]    hdr_cnt;
  logic [15:0]    rem_bytes;
  logic [2:0]     sub_cnt;
  logic [15:0]    total_length;
  logic [15:0]    data_length;
  logic [19:0]    csum_raw;
  logic [16:0]    csum_fold;
  logic [15:0]    csum;
  logic           dst_ok;
  logic           hdr_ok;
  logic           hdr_done;
  logic           pay_word;
  logic           pay_last;
  logic           trunc;

  // hdr_next is the complete header once the final header word is on axiid
  assign hdr_next     = {hdr_shift, axiid};
  assign total_length = hdr_next[143:128];
  assign data_length  = total_length - 16'd20;

  always_comb begin
    csum_raw = '0;
    for (int i = 0; i < 10; i++) begin
      csum_raw = csum_raw + 20'(hdr_next[159-16*i -: 16]);
    end
    csum_fold = 17'(csum_raw[15:0]) + 17'(csum_raw[19:16]);
    csum      = csum_fold[15:0] + 16'(csum_fold[16]);
  end

`ifdef IP_RX_DST_FILTER_EN
  assign dst_ok = (hdr_next[31:0] == LOCAL_IP) || (hdr_next[31:0] == 32'hFFFF_FFFF);
`else
  logic unused_local_ip;
  assign unused_local_ip = ^LOCAL_IP;
  assign dst_ok          = 1'b1;
`endif

  assign hdr_ok = (hdr_next[159:152] == 8'h45) && (csum == 16'hFFFF) &&
                  (total_length >= 16'd20) && dst_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    hdr_done   = 1'b0;
    pay_word   = 1'b0;
    pay_last   = 1'b0;
    trunc      = 1'b0;
    case (state)
      S_IDLE: begin
        if (axiiv) state_next = S_HEADER;
      end
      S_HEADER: begin
        if (!axiiv) begin
          trunc      = 1'b1;
          state_next = S_IDLE;
        end else if (hdr_cnt == HDR_LAST) begin
          hdr_done = 1'b1;
          if (!hdr_ok)                   state_next = S_DROP;
          else if (data_length == 16'd0) state_next = S_TRAIL;
          else                           state_next = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (!axiiv) begin
          trunc      = 1'b1;
          state_next = S_IDLE;
        end else begin
          pay_word = 1'b1;
          if (rem_bytes == 16'd1 && sub_cnt == SUB_LAST) begin
            pay_last   = 1'b1;
            state_next = S_TRAIL;
          end
        end
      end
      S_TRAIL, S_DROP: begin
        if (!axiiv) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Payload is counted in bytes plus words-within-byte so long frames never overflow 16 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_shift       <= '0;
      hdr_cnt         <= '0;
      rem_bytes       <= '0;
      sub_cnt         <= '0;
      axiov           <= 1'b0;
      axiod           <= '0;
      axi_last        <= 1'b0;
      hdr_valid       <= 1'b0;
      src_ip_out      <= '0;
      dst_ip_out      <= '0;
      protocol_out    <= '0;
      data_length_out <= '0;
      err             <= 1'b0;
    end else begin
      hdr_valid <= 1'b0;
      err       <= 1'b0;
      axiov     <= 1'b0;
      axi_last  <= 1'b0;
      if (axiiv && (state == S_IDLE || state == S_HEADER)) begin
        hdr_shift <= hdr_next[159-N:0];
        hdr_cnt   <= (state == S_IDLE) ? 16'd1 : hdr_cnt + 16'd1;
      end
      if (hdr_done) begin
        if (hdr_ok) begin
          hdr_valid       <= 1'b1;
          src_ip_out      <= hdr_next[63:32];
          dst_ip_out      <= hdr_next[31:0];
          protocol_out    <= hdr_next[87:80];
          data_length_out <= data_length;
          rem_bytes       <= data_length;
          sub_cnt         <= '0;
        end else begin
          err <= 1'b1;
        end
      end
      if (trunc) err <= 1'b1;
      if (pay_word) begin
        axiov    <= 1'b1;
        axiod    <= axiid;
        axi_last <= pay_last;
        if (sub_cnt == SUB_LAST) begin
          sub_cnt   <= '0;
          rem_bytes <= rem_bytes - 16'd1;
        end else begin
          sub_cnt <= sub_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_internet_protocol_rx.sv
// tb_internet_protocol_rx: directed table plus random frames for internet_protocol_rx at N = 2, 4, 8.
// Honours IP_RX_DST_FILTER_EN the same way the design does.
module tb_internet_protocol_rx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0;
  logic [1:0]  id0 = '0;
  logic [3:0]  id1 = '0;
  logic [7:0]  id2 = '0;
  logic        ov0, ov1, ov2, last0, last1, last2, hv0, hv1, hv2, er0, er1, er2;
  logic [1:0]  od0;
  logic [3:0]  od1;
  logic [7:0]  od2;
  logic [31:0] src0, src1, src2, dst0, dst1, dst2;
  logic [7:0]  pr0, pr1, pr2;
  logic [15:0] dl0, dl1, dl2;

  internet_protocol_rx #(.N(2)) dut_n2 (
    .clk(clk), .rst(rst), .axiiv(iv0), .axiid(id0), .axiov(ov0), .axiod(od0), .axi_last(last0),
    .hdr_valid(hv0), .src_ip_out(src0), .dst_ip_out(dst0), .protocol_out(pr0),
    .data_length_out(dl0), .err(er0));
  internet_protocol_rx #(.N(4)) dut_n4 (
    .clk(clk), .rst(rst), .axiiv(iv1), .axiid(id1), .axiov(ov1), .axiod(od1), .axi_last(last1),
    .hdr_valid(hv1), .src_ip_out(src1), .dst_ip_out(dst1), .protocol_out(pr1),
    .data_length_out(dl1), .err(er1));
  internet_protocol_rx #(.N(8)) dut_n8 (
    .clk(clk), .rst(rst), .axiiv(iv2), .axiid(id2), .axiov(ov2), .axiod(od2), .axi_last(last2),
    .hdr_valid(hv2), .src_ip_out(src2), .dst_ip_out(dst2), .protocol_out(pr2),
    .data_length_out(dl2), .err(er2));

  typedef struct {int sel; logic [7:0] w; int cyc; logic last;} ov_rec_t;
  typedef struct {
    int hv; int err; int words; int last;
    logic [31:0] src; logic [31:0] dst; logic [7:0] proto; logic [15:0] dl;
  } exp_t;
  typedef struct {
    int sel; logic [7:0] b0; logic [15:0] csum_xor; logic [31:0] dst; logic [15:0] tl;
    int hdr_bytes; int pay_sent; int pad;
    int exp_hv; int exp_err; int exp_words; int exp_last;
  } vec_t;

  ov_rec_t     ovq[$];
  vec_t        vecs[$];
  logic [7:0]  frame[$];
  logic [7:0]  exp_payload[$];
  int          hv_cnt = 0, err_cnt = 0, stray_last = 0, hv_cyc = 0, hdr_end_cyc = 0;
  int          ov_base = 0, hv_base = 0, err_base = 0, stray_base = 0;
  int          checks = 0, passes = 0;
  logic [31:0] cap_src = '0, cap_dst = '0;
  logic [7:0]  cap_proto = '0;
  logic [15:0] cap_dl = '0;

  task automatic sample(input int d, input logic ov, input logic [7:0] od, input logic lst,
                        input logic hv, input logic er, input logic [31:0] s,
                        input logic [31:0] ds, input logic [7:0] p, input logic [15:0] dl);
    ov_rec_t r;
    if (ov) begin
      r.sel = d; r.w = od; r.cyc = cyc; r.last = lst;
      ovq.push_back(r);
    end
    if (lst && !ov) stray_last++;
    if (hv) begin
      hv_cnt++; hv_cyc = cyc;
      cap_src = s; cap_dst = ds; cap_proto = p; cap_dl = dl;
    end
    if (er) err_cnt++;
  endtask

  // Everything the DUTs emit is logged on the falling edge, away from the sampling edge
  always @(negedge clk) begin
    sample(0, ov0, {6'd0, od0}, last0, hv0, er0, src0, dst0, pr0, dl0);
    sample(1, ov1, {4'd0, od1}, last1, hv1, er1, src1, dst1, pr1, dl1);
    sample(2, ov2, od2, last2, hv2, er2, src2, dst2, pr2, dl2);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
  endtask

  function automatic int width_of(input int sel);
    return (sel == 0) ? 2 : (sel == 1) ? 4 : 8;
  endfunction

  task automatic build_header(input logic [7:0] b0, input logic [15:0] tl, input logic [15:0] id,
                              input logic [7:0] proto, input logic [31:0] src,
                              input logic [31:0] dst, input logic [15:0] csum_xor);
    int sum;
    logic [15:0] c;
    frame.delete();
    frame.push_back(b0);       frame.push_back(8'h00);
    frame.push_back(tl[15:8]); frame.push_back(tl[7:0]);
    frame.push_back(id[15:8]); frame.push_back(id[7:0]);
    frame.push_back(8'h40);    frame.push_back(8'h00);
    frame.push_back(8'h40);    frame.push_back(proto);
    frame.push_back(8'h00);    frame.push_back(8'h00);
    for (int i = 3; i >= 0; i--) frame.push_back(src[8*i +: 8]);
    for (int i = 3; i >= 0; i--) frame.push_back(dst[8*i +: 8]);
    sum = 0;
    for (int i = 0; i < 10; i++) sum += {frame[2*i], frame[2*i+1]};
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    c = ~sum[15:0] ^ csum_xor;
    frame[10] = c[15:8];
    frame[11] = c[7:0];
  endtask

  // Reference: decide acceptance from the header bytes, then slice the payload out of the frame
  task automatic run_model(input int n, output exp_t e);
    int len, sum, tl, dl, got;
    logic [31:0] dst;
    bit ok;
    e = '{default: 0};
    exp_payload.delete();
    len = frame.size();
    if (len < 20) begin
      e.err = 1;
      return;
    end
    sum = 0;
    for (int i = 0; i < 10; i++) sum += {frame[2*i], frame[2*i+1]};
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    tl  = {frame[2], frame[3]};
    dst = {frame[16], frame[17], frame[18], frame[19]};
    ok  = (frame[0] == 8'h45) && (sum == 32'hFFFF) && (tl >= 20);
`ifdef IP_RX_DST_FILTER_EN
    ok = ok && (dst == 32'h12126B0D || dst == 32'hFFFFFFFF);
`endif
    if (!ok) begin
      e.err = 1;
      return;
    end
    e.hv    = 1;
    e.src   = {frame[12], frame[13], frame[14], frame[15]};
    e.dst   = dst;
    e.proto = frame[9];
    dl      = tl - 20;
    e.dl    = 16'(dl);
    got     = (len - 20 < dl) ? len - 20 : dl;
    for (int j = 0; j < got; j++) exp_payload.push_back(frame[20+j]);
    e.words = got * 8 / n;
    e.err   = (got < dl) ? 1 : 0;
    e.last  = (dl > 0 && got == dl) ? 1 : 0;
  endtask

  task automatic drive_word(input int sel, input logic v, input logic [7:0] w);
    case (sel)
      0:       begin iv0 = v; id0 = w[1:0]; end
      1:       begin iv1 = v; id1 = w[3:0]; end
      default: begin iv2 = v; id2 = w;      end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bytes(input int sel, input int count);
    int n, wpb;
    logic [7:0] b, w;
    n = width_of(sel);
    wpb = 8 / n;
    for (int i = 0; i < count; i++) begin
      b = frame[i];
      for (int k = 0; k < wpb; k++) begin
        w = 8'(b >> (8 - n * (k + 1))) & 8'((1 << n) - 1);
        if (i == 19 && k == wpb - 1) hdr_end_cyc = cyc;
        drive_word(sel, 1'b1, w);
      end
    end
  endtask

  task automatic applyStimulus(input int sel);
    ov_base = ovq.size(); hv_base = hv_cnt; err_base = err_cnt; stray_base = stray_last;
    drive_bytes(sel, frame.size());
    for (int i = 0; i < 5; i++) drive_word(sel, 1'b0, 8'h00);
  endtask

  task automatic check_frame(input string tag, input int sel, input exp_t e);
    int n, wpb, words, last_cnt, last_idx, bad, idx;
    logic [7:0] acc;
    n = width_of(sel);
    wpb = 8 / n;
    words = ovq.size() - ov_base;
    last_cnt = 0; last_idx = -1; bad = 0;
    checkOutput({tag, ".hdr_valid"}, hv_cnt - hv_base, e.hv);
    checkOutput({tag, ".err"}, err_cnt - err_base, e.err);
    checkOutput({tag, ".words"}, words, e.words);
    for (int j = ov_base; j < ovq.size(); j++) begin
      if (ovq[j].last) begin last_cnt++; last_idx = j - ov_base; end
      if (ovq[j].sel != sel) bad++;
    end
    checkOutput({tag, ".axi_last"}, last_cnt, e.last);
    checkOutput({tag, ".last_without_valid"}, stray_last - stray_base, 0);
    if (e.last != 0) checkOutput({tag, ".last_pos"}, last_idx, words - 1);
    for (int j = 0; j < exp_payload.size(); j++) begin
      acc = 8'h00;
      for (int k = 0; k < wpb; k++) begin
        idx = ov_base + j * wpb + k;
        if (idx < ovq.size()) acc = 8'((acc << n) | ovq[idx].w);
      end
      if (acc != exp_payload[j]) bad++;
    end
    checkOutput({tag, ".payload_bad_bytes"}, bad, 0);
    if (e.hv != 0) begin
      checkOutput({tag, ".src"}, cap_src, e.src);
      checkOutput({tag, ".dst"}, cap_dst, e.dst);
      checkOutput({tag, ".proto"}, {24'd0, cap_proto}, {24'd0, e.proto});
      checkOutput({tag, ".data_length"}, {16'd0, cap_dl}, {16'd0, e.dl});
      checkOutput({tag, ".hdr_latency"}, hv_cyc - hdr_end_cyc, 1);
      if (words > 0) checkOutput({tag, ".payload_latency"}, ovq[ov_base].cyc - hdr_end_cyc, 2);
    end
  endtask

  task automatic add_vec(input int sel, input logic [7:0] b0, input logic [15:0] cx,
                         input logic [31:0] dst, input logic [15:0] tl, input int hb,
                         input int ps, input int pad, input int ehv, input int eerr,
                         input int ew, input int el);
    vec_t v;
    v.sel = sel; v.b0 = b0; v.csum_xor = cx; v.dst = dst; v.tl = tl; v.hdr_bytes = hb;
    v.pay_sent = ps; v.pad = pad; v.exp_hv = ehv; v.exp_err = eerr; v.exp_words = ew;
    v.exp_last = el;
    vecs.push_back(v);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, ".axiov"}, {31'd0, ov1}, 0);
    checkOutput({tag, ".axi_last"}, {31'd0, last1}, 0);
    checkOutput({tag, ".hdr_valid"}, {31'd0, hv1}, 0);
    checkOutput({tag, ".err"}, {31'd0, er1}, 0);
    checkOutput({tag, ".src"}, src1, 0);
    checkOutput({tag, ".dst"}, dst1, 0);
    checkOutput({tag, ".proto"}, {24'd0, pr1}, 0);
    checkOutput({tag, ".data_length"}, {16'd0, dl1}, 0);
  endtask

  initial begin
    exp_t e;
    vec_t v;

    // sel, byte0, csum xor, dst, total_len, hdr bytes, payload sent, pad, hv, err, words, last
    add_vec(1, 8'h45, 16'h0000, 32'h12126B0D, 16'd32, 20, 12, 0, 1, 0, 24, 1);
    add_vec(1, 8'h45, 16'h0001, 32'h12126B0D, 16'd32, 20, 12, 0, 0, 1, 0, 0);
    add_vec(1, 8'h45, 16'h0000, 32'h12126B0D, 16'd32, 20, 12, 4, 1, 0, 24, 1);
    add_vec(1, 8'h45, 16'h0000, 32'h12126B0D, 16'd32, 20, 5, 0, 1, 1, 10, 0);
    add_vec(1, 8'h46, 16'h0000, 32'h12126B0D, 16'd32, 20, 12, 0, 0, 1, 0, 0);
    add_vec(1, 8'h55, 16'h0000, 32'h12126B0D, 16'd32, 20, 12, 0, 0, 1, 0, 0);
`ifdef IP_RX_DST_FILTER_EN
    add_vec(1, 8'h45, 16'h0000, 32'h0A000001, 16'd32, 20, 12, 0, 0, 1, 0, 0);
`else
    add_vec(1, 8'h45, 16'h0000, 32'h0A000001, 16'd32, 20, 12, 0, 1, 0, 24, 1);
`endif
    add_vec(1, 8'h45, 16'h0000, 32'hFFFFFFFF, 16'd32, 20, 12, 0, 1, 0, 24, 1);
    add_vec(1, 8'h45, 16'h0000, 32'h12126B0D, 16'd20, 20, 0, 3, 1, 0, 0, 0);
    add_vec(1, 8'h45, 16'h0000, 32'h12126B0D, 16'd19, 20, 0, 0, 0, 1, 0, 0);
    add_vec(1, 8'h45, 16'h0000, 32'h12126B0D, 16'd32, 10, 0, 0, 0, 1, 0, 0);
    add_vec(1, 8'h45, 16'h0000, 32'h12126B0D, 16'd32, 20, 0, 0, 1, 1, 0, 0);
    add_vec(0, 8'h45, 16'h0000, 32'h12126B0D, 16'd32, 20, 12, 0, 1, 0, 48, 1);
    add_vec(2, 8'h45, 16'h0000, 32'h12126B0D, 16'd32, 20, 12, 0, 1, 0, 12, 1);
    add_vec(2, 8'h45, 16'h0000, 32'h12126B0D, 16'd21, 20, 1, 0, 1, 0, 1, 1);
    add_vec(0, 8'h45, 16'h0000, 32'h12126B0D, 16'd21, 20, 1, 2, 1, 0, 4, 1);

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    for (int i = 0; i < 2; i++) drive_word(1, 1'b0, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      build_header(v.b0, v.tl, 16'h0000, 8'h11, 32'h69696969, v.dst, v.csum_xor);
      while (frame.size() > v.hdr_bytes) void'(frame.pop_back());
      for (int j = 0; j < v.pay_sent; j++) frame.push_back(8'($urandom));
      for (int j = 0; j < v.pad; j++) frame.push_back(8'($urandom));
      run_model(width_of(v.sel), e);
      e.hv = v.exp_hv; e.err = v.exp_err; e.words = v.exp_words; e.last = v.exp_last;
      applyStimulus(v.sel);
      check_frame($sformatf("vec%0d", i), v.sel, e);
    end

    // Reset part-way through a header must clear the fields left by earlier frames
    build_header(8'h45, 16'd32, 16'h0000, 8'h11, 32'h69696969, 32'h12126B0D, 16'h0000);
    drive_bytes(1, 10);
    iv1 = 1'b0;
    rst = 1'b0;
    #2;
    check_reset_outputs("rst_mid_header");
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) drive_word(1, 1'b0, 8'h00);

    // Reset part-way through the payload while axiov is active
    for (int j = 0; j < 12; j++) frame.push_back(8'($urandom));
    drive_bytes(1, 23);
    checkOutput("pre_reset_axiov", {31'd0, ov1}, 1);
    iv1 = 1'b0;
    rst = 1'b0;
    #2;
    check_reset_outputs("rst_mid_payload");
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) drive_word(1, 1'b0, 8'h00);

    run_model(4, e);
    applyStimulus(1);
    check_frame("after_reset", 1, e);

    for (int t = 0; t < 24; t++) begin
      int sel, tl, pad, mode, dsel;
      logic [31:0] dst;
      logic [7:0] b0;
      logic [15:0] cx;
      sel  = $urandom_range(0, 2);
      tl   = $urandom_range(20, 48);
      pad  = $urandom_range(0, 5);
      mode = $urandom_range(0, 7);
      dsel = $urandom_range(0, 2);
      dst  = (dsel == 0) ? 32'h12126B0D : (dsel == 1) ? 32'hFFFFFFFF : $urandom;
      b0   = (mode == 2) ? (($urandom_range(0, 1) == 0) ? 8'h46 : 8'h65) : 8'h45;
      cx   = (mode == 0) ? 16'($urandom_range(1, 16'hFFFF)) : 16'h0000;
      build_header(b0, 16'(tl), 16'($urandom), 8'($urandom), $urandom, dst, cx);
      for (int j = 0; j < tl - 20 + pad; j++) frame.push_back(8'($urandom));
      if (mode == 1) begin
        int keep;
        keep = $urandom_range(1, frame.size() - 1);
        while (frame.size() > keep) void'(frame.pop_back());
      end
      run_model(width_of(sel), e);
      applyStimulus(sel);
      check_frame($sformatf("rand%0d", t), sel, e);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
